// File: rtl/eth_internal_pkg.sv
// Shared types and elaboration helpers for the internal Ethernet egress arbiter.
package eth_internal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  // Beats per maximum-size packet; both operands are powers of two.
  function automatic int mtu_beats(input int byte_mtu, input int data_w);
    return (1 << byte_mtu) / (data_w / 8);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/eth_internal_egress_arb_if.sv
// Source-side and egress-side AXI-Stream bundle of the egress arbiter.
interface eth_internal_egress_arb_if
  import eth_internal_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64
);
  localparam int CH_W   = ch_w(NUM_CH);
  localparam int KEEP_W = DATA_W / 8;

  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH*KEEP_W-1:0] s_tkeep;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tready;

  logic [DATA_W-1:0]        m_tdata;
  logic [KEEP_W-1:0]        m_tkeep;
  logic                     m_tlast;
  logic                     m_tvalid;
  logic                     m_tready;
  logic [CH_W-1:0]          m_tsrc;

  // Sources and egress sink together.
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, m_tsrc
  );

  // The arbiter.
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, m_tsrc
  );

endinterface

// File: rtl/eth_internal_rr_pick.sv
// Combinational round-robin search: first requester after last_grant, wrapping.
module eth_internal_rr_pick
  import eth_internal_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              hit,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit is the one kept.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/eth_internal_egress_arb.sv
// Packet-level round-robin merge of NUM_CH AXI-Stream sources into one egress stream,
// with per-channel enables, MTU truncate-and-drop and saturating per-channel statistics.
module eth_internal_egress_arb
  import eth_internal_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 64,
  parameter int BYTE_MTU = 10,
  parameter int CNT_W    = 16
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst,
  eth_internal_egress_arb_if.slave axis,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     clear_stats,
  output logic [NUM_CH*CNT_W-1:0]  pkt_count,
  output logic [NUM_CH-1:0]        mtu_err
);

  localparam int CH_W      = ch_w(NUM_CH);
  localparam int KEEP_W    = DATA_W / 8;
  localparam int MTU_BEATS = mtu_beats(BYTE_MTU, DATA_W);
  localparam int BEAT_W    = $clog2(MTU_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MTU_BEATS - 1);

  arb_state_t        state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   last_grant;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];

  logic [CH_W-1:0]   pick;
  logic              pick_hit;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] rdy_vec;

  logic [DATA_W-1:0] ch_tdata [NUM_CH];
  logic [KEEP_W-1:0] ch_tkeep [NUM_CH];

  logic in_pass;
  logic in_drop;
  logic g_tvalid;
  logic g_tlast;
  logic at_mtu;
  logic beat_ok;
  logic drop_ok;
  logic pkt_done;
  logic mtu_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_tdata[i]                 = axis.s_tdata[i*DATA_W +: DATA_W];
    assign ch_tkeep[i]                 = axis.s_tkeep[i*KEEP_W +: KEEP_W];
    assign pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign req = axis.s_tvalid & ch_enable;

  eth_internal_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .hit        (pick_hit),
    .idx        (pick)
  );

  assign in_pass  = (state == PASS);
  assign in_drop  = (state == DROP);
  assign g_tvalid = axis.s_tvalid[grant];
  assign g_tlast  = axis.s_tlast[grant];
  assign at_mtu   = (beat_cnt == LAST_BEAT);
  assign beat_ok  = in_pass & g_tvalid & axis.m_tready;
  assign drop_ok  = in_drop & g_tvalid;
  assign pkt_done = beat_ok & (g_tlast | at_mtu);
  assign mtu_hit  = beat_ok & at_mtu & ~g_tlast;

  // Zero-latency data path; s_tready depends only on state, grant and m_tready.
  assign axis.m_tvalid = in_pass & g_tvalid;
  assign axis.m_tdata  = in_pass ? ch_tdata[grant] : '0;
  assign axis.m_tkeep  = in_pass ? ch_tkeep[grant] : '0;
  assign axis.m_tlast  = in_pass & (g_tlast | at_mtu);
  assign axis.m_tsrc   = grant;

  always_comb begin
    rdy_vec        = '0;
    rdy_vec[grant] = (in_pass & axis.m_tready) | in_drop;
  end

  assign axis.s_tready = rdy_vec;

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      beat_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (pick_hit) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= PASS;
          end
        end
        PASS: begin
          if (beat_ok) begin
            if (g_tlast) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else if (at_mtu) begin
              // Forced-last already went out; swallow the rest of this packet.
              state    <= DROP;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        DROP: begin
          if (drop_ok && g_tlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear takes priority over a coincident increment or error set.
  always_ff @(posedge bus_clk) begin
    if (bus_rst || clear_stats) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      mtu_err <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pkt_done && (grant == CH_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
        if (mtu_hit && (grant == CH_W'(i))) begin
          mtu_err[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_internal_egress_arb.sv
// Directed bench for eth_internal_egress_arb: 3 channels, 64-bit data, MTU of 8 beats, 2-bit counters.
module tb_eth_internal_egress_arb;

  localparam int NCH = 3;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int MTU = 8;
  localparam int CW  = 2;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
    logic [1:0]    src;
  } obeat_t;

  typedef struct {
    int         ch;
    int         nbeats;
    int         rdy;
    logic [2:0] exp_err;
    logic [5:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH-1:0]    ch_enable;
  logic              clear_stats;
  logic [NCH*CW-1:0] pkt_count;
  logic [NCH-1:0]    mtu_err;

  eth_internal_egress_arb_if #(.NUM_CH(NCH), .DATA_W(DW)) axis ();

  eth_internal_egress_arb #(
    .NUM_CH   (NCH),
    .DATA_W   (DW),
    .BYTE_MTU (6),
    .CNT_W    (CW)
  ) dut (
    .bus_clk     (clk),
    .bus_rst     (rst),
    .axis        (axis),
    .ch_enable   (ch_enable),
    .clear_stats (clear_stats),
    .pkt_count   (pkt_count),
    .mtu_err     (mtu_err)
  );

  beat_t  src_q [NCH][$];
  obeat_t out_q[$];
  int     out_cyc[$];
  int     cyc = 0;
  int     ready_pct = 100;
  int     tests = 0;
  int     fails = 0;
  int     pkt_first;
  int     pkt_end;
  vec_t   vec [5];

  function automatic logic [DW-1:0] mk_dat(input int ch, input int id, input int b);
    return {8'(ch), 8'(id), 8'(b), 40'h5A_C3_96_3C_E1};
  endfunction

  function automatic int pending();
    return src_q[0].size() + src_q[1].size() + src_q[2].size();
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NCH; i++) begin
      if (src_q[i].size() > 0) begin
        axis.s_tvalid[i]            = 1'b1;
        axis.s_tdata[i*DW +: DW]    = src_q[i][0].dat;
        axis.s_tkeep[i*KW +: KW]    = src_q[i][0].keep;
        axis.s_tlast[i]             = src_q[i][0].last;
      end else begin
        axis.s_tvalid[i]            = 1'b0;
        axis.s_tdata[i*DW +: DW]    = '0;
        axis.s_tkeep[i*KW +: KW]    = '0;
        axis.s_tlast[i]             = 1'b0;
      end
    end
    axis.m_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic add_pkt(input int ch, input int id, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.dat  = mk_dat(ch, id, k);
      b.keep = (k == nbeats - 1) ? 8'h0F : 8'hFF;
      b.last = (k == nbeats - 1);
      src_q[ch].push_back(b);
    end
    drive_inputs();
  endtask

  // Sample handshakes mid-cycle, then advance sources just after the edge.
  task automatic step();
    logic [NCH-1:0] fire;
    obeat_t o;
    @(negedge clk);
    fire = axis.s_tvalid & axis.s_tready;
    if (axis.m_tvalid && axis.m_tready) begin
      o.dat  = axis.m_tdata;
      o.keep = axis.m_tkeep;
      o.last = axis.m_tlast;
      o.src  = axis.m_tsrc;
      out_q.push_back(o);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (fire[i]) void'(src_q[i].pop_front());
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, " drained"}, 128'(pending()), 128'(0));
    step();
  endtask

  // Pop one emitted packet and compare every beat against the source model.
  task automatic chk_pkt(input string name, input int ch, input int id, input int nsrc);
    int nout;
    obeat_t o;
    nout = (nsrc > MTU) ? MTU : nsrc;
    chk({name, " beats present"}, 128'(out_q.size() >= nout), 128'(1));
    if (out_q.size() < nout) return;
    for (int b = 0; b < nout; b++) begin
      o = out_q.pop_front();
      if (b == 0) pkt_first = out_cyc[0];
      if (b == nout - 1) pkt_end = out_cyc[0];
      void'(out_cyc.pop_front());
      chk($sformatf("%s beat%0d", name, b), 128'(o),
          128'({mk_dat(ch, id, b), (b == nsrc - 1) ? 8'h0F : 8'hFF, b == nout - 1, 2'(ch)}));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_end;

    vec[0] = '{ch: 1, nbeats: 12, rdy: 50,  exp_err: 3'b010, exp_cnt: 6'b00_01_00};
    vec[1] = '{ch: 1, nbeats: 8,  rdy: 100, exp_err: 3'b000, exp_cnt: 6'b00_01_00};
    vec[2] = '{ch: 0, nbeats: 1,  rdy: 100, exp_err: 3'b000, exp_cnt: 6'b00_00_01};
    vec[3] = '{ch: 2, nbeats: 9,  rdy: 100, exp_err: 3'b100, exp_cnt: 6'b01_00_00};
    vec[4] = '{ch: 2, nbeats: 7,  rdy: 60,  exp_err: 3'b000, exp_cnt: 6'b01_00_00};

    rst           = 1'b1;
    ch_enable     = 3'b111;
    clear_stats   = 1'b0;
    axis.s_tvalid = '0;
    axis.s_tdata  = '0;
    axis.s_tkeep  = '0;
    axis.s_tlast  = '0;
    axis.m_tready = 1'b1;

    // Round robin: sources already requesting while reset is held.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NCH; c++) add_pkt(c, p, 4);
    end
    step();
    step();
    chk("rst s_tready", 128'(axis.s_tready), 128'(0));
    chk("rst m_tvalid", 128'(axis.m_tvalid), 128'(0));
    chk("rst m_tsrc", 128'(axis.m_tsrc), 128'(0));
    chk("rst pkt_count", 128'(pkt_count), 128'(0));
    chk("rst mtu_err", 128'(mtu_err), 128'(0));

    rst = 1'b0;
    step();
    chk("first grant m_tvalid", 128'(axis.m_tvalid), 128'(1));
    chk("first grant s_tready", 128'(axis.s_tready), 128'(3'b001));
    run_until_idle("rr", 300);
    prev_end = 0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NCH; c++) begin
        chk_pkt($sformatf("rr ch%0d p%0d", c, p), c, p, 4);
        if (p != 0 || c != 0) chk("rr bubble", 128'(pkt_first - prev_end), 128'(2));
        prev_end = pkt_end;
      end
    end
    chk("rr pkt_count", 128'(pkt_count), 128'(6'b10_10_10));
    chk("rr mtu_err", 128'(mtu_err), 128'(0));

    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clear pkt_count", 128'(pkt_count), 128'(0));

    // Throttled egress with mixed packet lengths.
    ready_pct = 50;
    add_pkt(0, 2, 1);
    add_pkt(1, 2, 5);
    add_pkt(2, 2, 1);
    add_pkt(0, 3, 5);
    add_pkt(1, 3, 1);
    run_until_idle("thr", 400);
    chk_pkt("thr ch0 p2", 0, 2, 1);
    chk_pkt("thr ch1 p2", 1, 2, 5);
    chk_pkt("thr ch2 p2", 2, 2, 1);
    chk_pkt("thr ch0 p3", 0, 3, 5);
    chk_pkt("thr ch1 p3", 1, 3, 1);
    chk("thr no extra beats", 128'(out_q.size()), 128'(0));
    chk("thr pkt_count", 128'(pkt_count), 128'(6'b01_10_10));
    ready_pct = 100;

    // Single-packet vectors around the MTU boundary.
    for (int v = 0; v < 5; v++) begin
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      ready_pct = vec[v].rdy;
      add_pkt(vec[v].ch, 20 + v, vec[v].nbeats);
      run_until_idle($sformatf("vec%0d", v), 300);
      chk_pkt($sformatf("vec%0d", v), vec[v].ch, 20 + v, vec[v].nbeats);
      chk($sformatf("vec%0d extra beats", v), 128'(out_q.size()), 128'(0));
      chk($sformatf("vec%0d mtu_err", v), 128'(mtu_err), 128'(vec[v].exp_err));
      chk($sformatf("vec%0d pkt_count", v), 128'(pkt_count), 128'(vec[v].exp_cnt));
    end
    ready_pct = 100;

    // Disabling ch0 mid-packet: current packet finishes, ch0 then skipped.
    add_pkt(0, 10, 6);
    add_pkt(0, 11, 2);
    add_pkt(1, 10, 2);
    add_pkt(1, 11, 2);
    step();
    step();
    step();
    ch_enable = 3'b110;
    for (int n = 0; n < 60 && out_q.size() < 10; n++) step();
    repeat (6) step();
    chk("en beat count", 128'(out_q.size()), 128'(10));
    chk_pkt("en ch0 p10", 0, 10, 6);
    chk_pkt("en ch1 p10", 1, 10, 2);
    chk_pkt("en ch1 p11", 1, 11, 2);
    chk("en ch0 held off", 128'({axis.m_tvalid, axis.s_tvalid[0]}), 128'(2'b01));
    ch_enable = 3'b111;
    run_until_idle("en", 100);
    chk_pkt("en ch0 p11", 0, 11, 2);

    // Counter saturation and clear priority.
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    for (int p = 0; p < 5; p++) add_pkt(0, 30 + p, 1);
    run_until_idle("sat", 100);
    for (int p = 0; p < 5; p++) chk_pkt($sformatf("sat p%0d", p), 0, 30 + p, 1);
    chk("sat pkt_count", 128'(pkt_count), 128'(6'b00_00_11));

    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 35 + p, 1);
      step();
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      step();
      chk($sformatf("clear wins p%0d", p), 128'(pkt_count), 128'(0));
      chk_pkt($sformatf("clear wins p%0d", p), 0, 35 + p, 1);
    end
    add_pkt(0, 37, 1);
    run_until_idle("post clear", 50);
    chk_pkt("post clear", 0, 37, 1);
    chk("post clear pkt_count", 128'(pkt_count), 128'(6'b00_00_01));

    // Clear coinciding with the forced-last beat of an oversize packet.
    add_pkt(2, 40, 10);
    repeat (8) step();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    run_until_idle("trunc clr", 100);
    chk_pkt("trunc clr", 2, 40, 10);
    chk("trunc clr mtu_err", 128'(mtu_err), 128'(0));
    chk("trunc clr pkt_count", 128'(pkt_count), 128'(0));
    chk("final no extra beats", 128'(out_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_internal_egress_arb.md
# eth_internal_egress_arb

Packet-level round-robin arbiter that merges NUM_CH AXI-Stream sources (host DMA, RFNoC CHDR, CPU) into one egress stream toward the Ethernet MAC/IPv4 framer. It generalises the fixed two-source internal Ethernet path to a parametrised channel count and data width. It adds per-channel enables, MTU enforcement with truncate-and-drop, and per-channel packet statistics. It sits between the source adapters and the egress framer inside the internal Ethernet port.

## Interface
Parameters:
- NUM_CH, 2, number of input channels (1..8)
- DATA_W, 64, data width in bits; multiple of 8 (64, 128, 256, 512)
- BYTE_MTU, 10, log2 of max packet size in bytes; MTU_BEATS = 2^BYTE_MTU / (DATA_W/8), must be ≥ 2
- CNT_W, 16, packet counter width

Ports:
- bus_clk  in  1  single clock for all logic
- bus_rst  in  1  synchronous, active-high reset
- s_tdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- s_tkeep  in  NUM_CH*DATA_W/8  byte enables per channel
- s_tlast  in  NUM_CH  end of packet
- s_tvalid  in  NUM_CH
- s_tready  out  NUM_CH
- m_tdata  out  DATA_W
- m_tkeep  out  DATA_W/8
- m_tlast  out  1
- m_tvalid  out  1
- m_tready  in  1
- m_tsrc  out  max(1,$clog2(NUM_CH))  index of the channel currently granted
- ch_enable  in  NUM_CH  channel may win arbitration when 1
- clear_stats  in  1  one-cycle pulse; zeroes counters and error flags
- pkt_count  out  NUM_CH*CNT_W  packets emitted per channel, saturating
- mtu_err  out  NUM_CH  sticky; set when a channel packet exceeded MTU_BEATS

## Operation
- States: IDLE, PASS, DROP.
- IDLE:
  - Search channels starting at (last_grant+1) mod NUM_CH for the first i with s_tvalid[i] & ch_enable[i].
  - On a hit, register grant=i, set last_grant=i, go to PASS.
  - All s_tready=0 and m_tvalid=0 in IDLE.
- PASS:
  - m_tdata/m_tkeep/m_tvalid follow channel grant combinationally.
  - s_tready[grant]=m_tready; every other s_tready=0.
  - beat_cnt increments on each accepted beat (m_tvalid & m_tready).
  - m_tlast = s_tlast[grant] | (beat_cnt == MTU_BEATS-1).
  - Accepted beat with s_tlast: increment pkt_count[grant], go to IDLE.
  - Accepted forced-last beat without s_tlast: increment pkt_count[grant], set mtu_err[grant], go to DROP.
- DROP:
  - s_tready[grant]=1 and m_tvalid=0.
  - Discard beats until an accepted beat with s_tlast, then go to IDLE.
- Grant is held for a whole packet. Deasserting ch_enable mid-packet takes effect only at the next arbitration.
- m_tsrc equals grant throughout PASS and DROP, and is stable for the packet.
- Counters saturate at 2^CNT_W-1.
- clear_stats zeroes all pkt_count and mtu_err. If clear_stats coincides with an increment or an error set, clear wins.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=NUM_CH-1 (first search starts at channel 0), beat_cnt=0.
  - m_tvalid=0, all s_tready=0, m_tsrc=0, pkt_count=0, mtu_err=0.
- Arbitration costs exactly one IDLE cycle per packet. Back-to-back packets therefore have a one-cycle bubble.
- Data path has zero latency: m_* are combinational from the granted s_* in PASS. There is no combinational path from s_tvalid to s_tready.
- AXI-Stream rules apply:
  - m_tvalid, once high, stays high with data stable until accepted. This holds provided the sources obey AXI.
  - Backpressure from m_tready propagates to s_tready[grant] in the same cycle.
- A single-beat packet (tlast on beat 0) gives PASS for one accepted cycle, then IDLE.
- A packet of exactly MTU_BEATS beats whose last beat carries s_tlast is legal. It sets no error and is followed by no DROP.
- Reset asserted mid-packet: return to IDLE next cycle. The partially sent packet is not terminated; the downstream framer handles it.

## Structure
- Package eth_internal_pkg holds:
  - the state enum (IDLE, PASS, DROP);
  - a function computing MTU_BEATS from BYTE_MTU and DATA_W;
  - the CH_W = max(1,$clog2(NUM_CH)) helper.
- Sub-module eth_internal_rr_pick: combinational round-robin search. Inputs are the request vector and last_grant; outputs are a hit flag and the index.
- Everything else (FSM, mux, beat counter, stats) lives in the top module.

## Test plan
- NUM_CH=3, all enabled, each channel queues two 4-beat packets -> output order ch0,ch1,ch2,ch0,ch1,ch2; m_tsrc matches; pkt_count={2,2,2}; one idle cycle between packets.
- Random m_tready throttling (50%) on 1-beat and 5-beat packets -> output beats are byte-identical to the input, with no loss and no duplicate beats.
- DATA_W=64, BYTE_MTU=6 (MTU_BEATS=8), ch1 sends a 12-beat packet -> 8 beats out with m_tlast on beat 8, then 4 beats dropped; mtu_err=3'b010; pkt_count[1]=1.
- Exactly 8-beat packet with BYTE_MTU=6 -> passes intact; mtu_err stays 0.
- ch_enable[0] cleared mid-packet on ch0 -> packet completes; ch0 is not granted afterward while ch1 is served.
- CNT_W=2, 5 packets on ch0 -> pkt_count[0] saturates at 3. clear_stats coinciding with the 6th tlast -> pkt_count[0]=0.
